// File: rtl/spm_ctrl_pkg.sv
// Shared constants, grant encodings and helpers for the scratchpad-memory controller.
package spm_ctrl_pkg;

    localparam int   WORD_ADDR_W   = 30;
    localparam int   WORD_DATA_W   = 32;
    localparam logic READ          = 1'b1;
    localparam logic WRITE         = 1'b0;

    localparam int   SPM_IDX_W     = 12;
    localparam int   SPM_DRAIN_MAX = 4;

    typedef enum logic [1:0] {
        GNT_NONE  = 2'd0,
        GNT_DRAIN = 2'd1,
        GNT_MEM   = 2'd2,
        GNT_IF    = 2'd3
    } gnt_e;

    // Parity bit that makes the stored word plus parity XOR to zero.
    function automatic logic even_parity(input logic [WORD_DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/spm_ctrl_if.sv
// Strobe bus bundle for the IF (read-only) and MEM (load/store) scratchpad ports.
interface spm_ctrl_if;
    import spm_ctrl_pkg::*;

    logic [WORD_ADDR_W-1:0] if_addr;
    logic                   if_as_;
    logic [WORD_DATA_W-1:0] if_rd_data;
    logic                   if_rdy;

    logic [WORD_ADDR_W-1:0] mem_addr;
    logic                   mem_as_;
    logic                   mem_rw;
    logic [WORD_DATA_W-1:0] mem_wr_data;
    logic [WORD_DATA_W-1:0] mem_rd_data;
    logic                   mem_rdy;

    modport master (
        output if_addr, if_as_, mem_addr, mem_as_, mem_rw, mem_wr_data,
        input  if_rd_data, if_rdy, mem_rd_data, mem_rdy
    );

    modport slave (
        input  if_addr, if_as_, mem_addr, mem_as_, mem_rw, mem_wr_data,
        output if_rd_data, if_rdy, mem_rd_data, mem_rdy
    );

endinterface

// File: rtl/spm_ram.sv
// Single-port synchronous RAM: one access per cycle, read data registered one cycle later.
module spm_ram #(
    parameter int IDX_W  = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [2**IDX_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en && we) begin
            mem_q[idx] <= wdata;
        end
        if (en && !we) begin
            rdata_q <= mem_q[idx];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/spm_ctrl.sv
// Scratchpad responder: IF/MEM reads and a one-entry posted write buffer share one RAM port.
// Build option: define SPM_PARITY_EN to store and check an even-parity bit per word.
module spm_ctrl
    import spm_ctrl_pkg::*;
#(
    parameter int IDX_W     = SPM_IDX_W,
    parameter int DRAIN_MAX = SPM_DRAIN_MAX
) (
    input  logic      clk,
    input  logic      reset,
    spm_ctrl_if.slave bus,
    output logic      spm_par_err
);

    localparam int               AGE_W   = $clog2(DRAIN_MAX + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(DRAIN_MAX);
`ifdef SPM_PARITY_EN
    localparam int               RAM_W   = WORD_DATA_W + 1;
`else
    localparam int               RAM_W   = WORD_DATA_W;
`endif

    function automatic logic [AGE_W-1:0] age_sat_inc(input logic [AGE_W-1:0] age);
        return (age == AGE_MAX) ? AGE_MAX : age + AGE_W'(1);
    endfunction

    logic [IDX_W-1:0]       if_idx, mem_idx;
    logic                   if_req, mem_rd_req, mem_wr_req, if_hit, mem_hit;
    gnt_e                   gnt;

    logic                   wb_v_q, wb_v_d;
    logic [IDX_W-1:0]       wb_idx_q, wb_idx_d;
    logic [WORD_DATA_W-1:0] wb_data_q, wb_data_d;
    logic [AGE_W-1:0]       wb_age_q, wb_age_d;

    logic                   if_rdy_q, if_rdy_d, mem_rdy_q, mem_rdy_d;
    logic                   if_ram_q, if_ram_d, mem_ram_q, mem_ram_d;
    logic [WORD_DATA_W-1:0] if_data_q, if_data_d, mem_data_q, mem_data_d;

    logic                   ram_en, ram_we;
    logic [IDX_W-1:0]       ram_idx;
    logic [RAM_W-1:0]       ram_wdata, ram_rdata;
    logic [WORD_DATA_W-1:0] ram_word;
    logic                   unused_addr_hi;

    assign if_idx         = bus.if_addr[IDX_W-1:0];
    assign mem_idx        = bus.mem_addr[IDX_W-1:0];
    assign unused_addr_hi = ^{bus.if_addr[WORD_ADDR_W-1:IDX_W], bus.mem_addr[WORD_ADDR_W-1:IDX_W]};

    assign if_req     = !bus.if_as_;
    assign mem_rd_req = !bus.mem_as_ && (bus.mem_rw == READ);
    assign mem_wr_req = !bus.mem_as_ && (bus.mem_rw == WRITE);
    assign if_hit     = wb_v_q && (if_idx == wb_idx_q);
    assign mem_hit    = wb_v_q && (mem_idx == wb_idx_q);

    // One array slot per cycle; reads that hit the write buffer never compete for it.
    always_comb begin
        gnt = GNT_NONE;
        if (wb_v_q && (mem_wr_req || wb_age_q == AGE_MAX)) begin
            gnt = GNT_DRAIN;
        end else if (mem_rd_req && !mem_hit) begin
            gnt = GNT_MEM;
        end else if (if_req && !if_hit) begin
            gnt = GNT_IF;
        end else if (wb_v_q) begin
            gnt = GNT_DRAIN;
        end
    end

    always_comb begin
        ram_en  = (gnt != GNT_NONE);
        ram_we  = (gnt == GNT_DRAIN);
        ram_idx = '0;
        case (gnt)
            GNT_DRAIN: ram_idx = wb_idx_q;
            GNT_MEM:   ram_idx = mem_idx;
            GNT_IF:    ram_idx = if_idx;
            default:   ram_idx = '0;
        endcase
    end

    assign ram_word = ram_rdata[WORD_DATA_W-1:0];

`ifdef SPM_PARITY_EN
    assign ram_wdata   = {even_parity(wb_data_q), wb_data_q};
    assign spm_par_err = (if_ram_q || mem_ram_q) && (^ram_rdata);
`else
    assign ram_wdata   = wb_data_q;
    assign spm_par_err = 1'b0;
`endif

    // A new store always loads the buffer; any drain in the same cycle writes the old entry.
    always_comb begin
        wb_v_d    = wb_v_q;
        wb_idx_d  = wb_idx_q;
        wb_data_d = wb_data_q;
        wb_age_d  = wb_age_q;
        if (mem_wr_req) begin
            wb_v_d    = 1'b1;
            wb_idx_d  = mem_idx;
            wb_data_d = bus.mem_wr_data;
            wb_age_d  = '0;
        end else if (gnt == GNT_DRAIN) begin
            wb_v_d   = 1'b0;
            wb_age_d = '0;
        end else if (wb_v_q) begin
            wb_age_d = age_sat_inc(wb_age_q);
        end
    end

    // Read data is muxed from the RAM output in the rdy cycle and then held in *_data_q.
    always_comb begin
        if_rdy_d   = if_req && (if_hit || gnt == GNT_IF);
        if_ram_d   = (gnt == GNT_IF);
        mem_rdy_d  = mem_wr_req || (mem_rd_req && (mem_hit || gnt == GNT_MEM));
        mem_ram_d  = (gnt == GNT_MEM);
        if_data_d  = if_data_q;
        mem_data_d = mem_data_q;
        if (if_ram_q) begin
            if_data_d = ram_word;
        end
        if (mem_ram_q) begin
            mem_data_d = ram_word;
        end
        if (if_req && if_hit) begin
            if_data_d = wb_data_q;
        end
        if (mem_rd_req && mem_hit) begin
            mem_data_d = wb_data_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_v_q     <= 1'b0;
            wb_age_q   <= '0;
            if_rdy_q   <= 1'b0;
            mem_rdy_q  <= 1'b0;
            if_ram_q   <= 1'b0;
            mem_ram_q  <= 1'b0;
            if_data_q  <= '0;
            mem_data_q <= '0;
        end else begin
            wb_v_q     <= wb_v_d;
            wb_age_q   <= wb_age_d;
            if_rdy_q   <= if_rdy_d;
            mem_rdy_q  <= mem_rdy_d;
            if_ram_q   <= if_ram_d;
            mem_ram_q  <= mem_ram_d;
            if_data_q  <= if_data_d;
            mem_data_q <= mem_data_d;
        end
    end

    always_ff @(posedge clk) begin
        wb_idx_q  <= wb_idx_d;
        wb_data_q <= wb_data_d;
    end

    assign bus.if_rdy      = if_rdy_q;
    assign bus.if_rd_data  = if_ram_q ? ram_word : if_data_q;
    assign bus.mem_rdy     = mem_rdy_q;
    assign bus.mem_rd_data = mem_ram_q ? ram_word : mem_data_q;

    spm_ram #(
        .IDX_W  (IDX_W),
        .DATA_W (RAM_W)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .idx   (ram_idx),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_spm_ctrl.sv
// Testbench for spm_ctrl: directed handshake/contention/aging/reset steps plus a randomized
// two-initiator phase checked against a plain array model of memory contents.
module tb_spm_ctrl;
    import spm_ctrl_pkg::*;

    localparam int IDX_W     = 12;
    localparam int DRAIN_MAX = 4;
    localparam int NIDX      = 16;

    logic clk = 1'b0;
    logic reset;
    logic spm_par_err;
    int   checks = 0;
    int   errors = 0;
    logic [WORD_DATA_W-1:0] model [NIDX];

    spm_ctrl_if bus ();

    spm_ctrl #(
        .IDX_W     (IDX_W),
        .DRAIN_MAX (DRAIN_MAX)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .spm_par_err (spm_par_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WORD_ADDR_W-1:0] mk_addr(input int idx);
        logic [WORD_ADDR_W-1:0] a;
        a = WORD_ADDR_W'($urandom);
        a[IDX_W-1:0] = IDX_W'(idx);
        return a;
    endfunction

    task automatic drv_if(input int idx);
        bus.if_as_  = 1'b0;
        bus.if_addr = mk_addr(idx);
    endtask

    task automatic drv_mem(input logic rw, input int idx, input logic [31:0] d);
        bus.mem_as_     = 1'b0;
        bus.mem_rw      = rw;
        bus.mem_addr    = mk_addr(idx);
        bus.mem_wr_data = d;
    endtask

    task automatic idle_all();
        bus.if_as_  = 1'b1;
        bus.mem_as_ = 1'b1;
    endtask

    initial begin
        int   stalls;
        int   cur;
        bit   if_pend, mem_pend;
        int   if_idx, mem_idx, if_wait, mem_wait;
        logic mem_op;
        logic [31:0] mem_wd;
        logic [31:0] newv;

        reset           = 1'b0;
        bus.if_as_      = 1'b1;
        bus.if_addr     = '0;
        bus.mem_as_     = 1'b1;
        bus.mem_rw      = READ;
        bus.mem_addr    = '0;
        bus.mem_wr_data = '0;
        repeat (3) tick();
        chk("rst_if_rdy", 32'(bus.if_rdy), 32'd0);
        chk("rst_mem_rdy", 32'(bus.mem_rdy), 32'd0);
        chk("rst_if_data", bus.if_rd_data, 32'd0);
        chk("rst_mem_data", bus.mem_rd_data, 32'd0);
        chk("rst_par_err", 32'(spm_par_err), 32'd0);
        reset = 1'b1;
        tick();

        // Front-door preload; consecutive stores force drains of the previous entry.
        for (int i = 0; i < NIDX; i++) begin
            model[i] = (i == 5) ? 32'hDEAD_BEEF : $urandom;
            drv_mem(WRITE, i, model[i]);
            tick();
            chk("preload_mem_rdy", 32'(bus.mem_rdy), 32'd1);
        end
        idle_all();
        tick();

        // IF read only, back-to-back.
        drv_if(5);
        tick();
        chk("t1_if_rdy0", 32'(bus.if_rdy), 32'd1);
        chk("t1_if_data0", bus.if_rd_data, 32'hDEAD_BEEF);
        drv_if(6);
        tick();
        chk("t1_if_rdy1", 32'(bus.if_rdy), 32'd1);
        chk("t1_if_data1", bus.if_rd_data, model[6]);
        idle_all();
        tick();
        chk("t1_rdy_pulse", 32'(bus.if_rdy), 32'd0);
        chk("t1_data_hold", bus.if_rd_data, model[6]);

        // Contention: MEM read wins the slot, IF retries.
        drv_mem(READ, 7, 32'd0);
        drv_if(8);
        tick();
        chk("t2_mem_rdy", 32'(bus.mem_rdy), 32'd1);
        chk("t2_mem_data", bus.mem_rd_data, model[7]);
        chk("t2_if_nordy", 32'(bus.if_rdy), 32'd0);
        bus.mem_as_ = 1'b1;
        tick();
        chk("t2_if_rdy", 32'(bus.if_rdy), 32'd1);
        chk("t2_if_data", bus.if_rd_data, model[8]);
        chk("t2_mem_nordy", 32'(bus.mem_rdy), 32'd0);
        chk("t2_mem_hold", bus.mem_rd_data, model[7]);
        idle_all();
        tick();

        // Store bypass and IF latency while the buffer is full.
        drv_mem(WRITE, 3, 32'h1234_5678);
        tick();
        chk("t3_wr_rdy", 32'(bus.mem_rdy), 32'd1);
        model[3] = 32'h1234_5678;
        drv_mem(READ, 3, 32'd0);
        drv_if(10);
        tick();
        chk("t3_byp_rdy", 32'(bus.mem_rdy), 32'd1);
        chk("t3_byp_data", bus.mem_rd_data, 32'h1234_5678);
        chk("t3_if_rdy", 32'(bus.if_rdy), 32'd1);
        chk("t3_if_data", bus.if_rd_data, model[10]);
        bus.mem_as_ = 1'b1;
        drv_if(11);
        tick();
        chk("t3_if_rdy2", 32'(bus.if_rdy), 32'd1);
        chk("t3_if_data2", bus.if_rd_data, model[11]);
        idle_all();
        tick();

        // Back-to-back stores and forced drain under IF pressure.
        model[1] = $urandom;
        model[2] = $urandom;
        drv_mem(WRITE, 1, model[1]);
        drv_if(12);
        tick();
        chk("t4_wr1_rdy", 32'(bus.mem_rdy), 32'd1);
        chk("t4_if_rdy", 32'(bus.if_rdy), 32'd1);
        chk("t4_if_data", bus.if_rd_data, model[12]);
        drv_mem(WRITE, 2, model[2]);
        drv_if(13);
        tick();
        chk("t4_wr2_rdy", 32'(bus.mem_rdy), 32'd1);
        chk("t4_if_lost_to_drain", 32'(bus.if_rdy), 32'd0);
        bus.mem_as_ = 1'b1;
        cur    = 13;
        stalls = 0;
        for (int k = 0; k < 2 * DRAIN_MAX; k++) begin
            tick();
            if (bus.if_rdy) begin
                chk("t4_hammer_data", bus.if_rd_data, model[cur]);
                cur = (cur == 13) ? 14 : 13;
                drv_if(cur);
            end else begin
                stalls++;
            end
        end
        chk("t4_forced_drain_stalls", 32'(stalls), 32'd1);
        drv_if(1);
        tick();
        chk("t4_rd1", bus.if_rd_data, model[1]);
        drv_if(2);
        tick();
        chk("t4_rd2", bus.if_rd_data, model[2]);
        drv_mem(READ, 1, 32'd0);
        idle_all();
        drv_mem(READ, 1, 32'd0);
        tick();
        chk("t4_mem_rd1", bus.mem_rd_data, model[1]);
        idle_all();
        tick();

        // Reset while a store sits in the buffer: the store is lost, array keeps old data.
        newv = ~model[4];
        drv_mem(WRITE, 4, newv);
        tick();
        chk("t5_wr_rdy", 32'(bus.mem_rdy), 32'd1);
        idle_all();
        reset = 1'b0;
        #1;
        chk("t5_if_rdy", 32'(bus.if_rdy), 32'd0);
        chk("t5_mem_rdy", 32'(bus.mem_rdy), 32'd0);
        chk("t5_if_data", bus.if_rd_data, 32'd0);
        chk("t5_mem_data", bus.mem_rd_data, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        drv_if(4);
        tick();
        chk("t5_post_rdy", 32'(bus.if_rdy), 32'd1);
        chk("t5_post_old", bus.if_rd_data, model[4]);
        idle_all();
        tick();

        // Randomized traffic on both ports against the array model.
        if_pend  = 1'b0;
        mem_pend = 1'b0;
        if_idx   = 0;
        mem_idx  = 0;
        if_wait  = 0;
        mem_wait = 0;
        mem_op   = READ;
        mem_wd   = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!if_pend) begin
                if ($urandom_range(0, 9) < 7) begin
                    if_idx  = $urandom_range(0, NIDX - 1);
                    if_pend = 1'b1;
                    if_wait = 0;
                    drv_if(if_idx);
                end else begin
                    bus.if_as_ = 1'b1;
                end
            end
            if (!mem_pend) begin
                if ($urandom_range(0, 9) < 5) begin
                    mem_idx  = $urandom_range(0, NIDX - 1);
                    mem_op   = ($urandom_range(0, 1) == 0) ? READ : WRITE;
                    mem_wd   = $urandom;
                    mem_pend = 1'b1;
                    mem_wait = 0;
                    drv_mem(mem_op, mem_idx, mem_wd);
                end else begin
                    bus.mem_as_ = 1'b1;
                end
            end
            tick();
            chk("rnd_par_err", 32'(spm_par_err), 32'd0);
            if (if_pend) begin
                if (bus.if_rdy) begin
                    chk("rnd_if_data", bus.if_rd_data, model[if_idx]);
                    if_pend = 1'b0;
                end else if (++if_wait > 40) begin
                    chk("rnd_if_timeout", 32'(if_wait), 32'd0);
                    if_pend = 1'b0;
                end
            end else begin
                chk("rnd_if_spurious", 32'(bus.if_rdy), 32'd0);
            end
            if (mem_pend) begin
                if (bus.mem_rdy) begin
                    if (mem_op == READ) begin
                        chk("rnd_mem_data", bus.mem_rd_data, model[mem_idx]);
                    end else begin
                        model[mem_idx] = mem_wd;
                    end
                    mem_pend = 1'b0;
                end else if (++mem_wait > 40) begin
                    chk("rnd_mem_timeout", 32'(mem_wait), 32'd0);
                    mem_pend = 1'b0;
                end
            end else begin
                chk("rnd_mem_spurious", 32'(bus.mem_rdy), 32'd0);
            end
        end
        idle_all();
        tick();
        tick();

        // Parity: a corrupted word is flagged with its rdy and returned unchanged.
`ifdef SPM_PARITY_EN
        dut.u_ram.mem_q[9][0] = ~dut.u_ram.mem_q[9][0];
        drv_if(9);
        tick();
        chk("t6_if_rdy", 32'(bus.if_rdy), 32'd1);
        chk("t6_par_err", 32'(spm_par_err), 32'd1);
        chk("t6_data_raw", bus.if_rd_data, model[9] ^ 32'd1);
        idle_all();
        tick();
        chk("t6_par_pulse", 32'(spm_par_err), 32'd0);
`else
        drv_if(9);
        tick();
        chk("t6_if_rdy", 32'(bus.if_rdy), 32'd1);
        chk("t6_par_err_off", 32'(spm_par_err), 32'd0);
        chk("t6_data", bus.if_rd_data, model[9]);
        idle_all();
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
